// File: rtl/mini_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mini_ram_arb_pkg
//  Description : Shared types and defaults for the mini_ram_arb RAM arbiter:
//                owner-state encoding, in-flight read tag and width defaults.
//  Revision    : 1.0  initial release
// ============================================================================
package mini_ram_arb_pkg;

    localparam int c_AW        = 8;
    localparam int c_DW        = 8;
    localparam int c_MAX_BURST = 4;

    // Last port accepted by the arbiter
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } own_e;

    // Tag carried alongside a read while it is in flight to the RAM
    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    // Port id to one-hot grant vector
    function automatic logic [1:0] f_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mini_ram_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mini_ram_arb_if
//  Description : Bundle of both requester ports and the RAM command/return
//                path seen by mini_ram_arb.
//  Revision    : 1.0  initial release
// ============================================================================
interface mini_ram_arb_if
    import mini_ram_arb_pkg::*;
#(
    parameter int AW = c_AW,
    parameter int DW = c_DW
);
    logic          p0_valid;
    logic          p0_wr;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ready;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;

    logic          p1_valid;
    logic          p1_wr;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ready;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wr;
    logic          ram_rd;
    logic [DW-1:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  p0_valid, p0_wr, p0_addr, p0_wdata,
        output p0_ready, p0_rvalid, p0_rdata,
        input  p1_valid, p1_wr, p1_addr, p1_wdata,
        output p1_ready, p1_rvalid, p1_rdata,
        output ram_addr, ram_wdata, ram_wr, ram_rd,
        input  ram_rdata
    );

    // Requester / RAM side
    modport master (
        output p0_valid, p0_wr, p0_addr, p0_wdata,
        input  p0_ready, p0_rvalid, p0_rdata,
        output p1_valid, p1_wr, p1_addr, p1_wdata,
        input  p1_ready, p1_rvalid, p1_rdata,
        input  ram_addr, ram_wdata, ram_wr, ram_rd,
        output ram_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mini_ram_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mini_rr_arb2
//  Description : Two-way round-robin arbiter with bounded burst. Tracks the
//                last owner, a burst counter and a tie-break pointer used
//                when both ports request from idle.
//  Revision    : 1.0  initial release
// ============================================================================
module mini_rr_arb2
    import mini_ram_arb_pkg::*;
#(
    parameter int MAX_BURST = c_MAX_BURST
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [1:0] valid,
    output logic      [1:0] grant
);

    localparam int               c_BCW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_BCW-1:0] c_BLAST = c_BCW'(MAX_BURST - 1);

    own_e             r_state;
    logic [c_BCW-1:0] r_bcnt;
    logic             r_ptr;

    logic w_any;
    logic w_win;
    logic w_yield;
    logic w_same;

    // Pick the winner: sole requester, else owner until its burst is spent
    always_comb begin
        w_any   = |valid;
        w_win   = 1'b0;
        w_yield = 1'b0;
        if (&valid) begin
            case (r_state)
                OWN0: begin
                    w_yield = (r_bcnt == c_BLAST);
                    w_win   = w_yield;
                end
                OWN1: begin
                    w_yield = (r_bcnt == c_BLAST);
                    w_win   = ~w_yield;
                end
                default: w_win = r_ptr;
            endcase
        end else begin
            w_win = valid[1];
        end
        w_same = ((r_state == OWN0) && !w_win) || ((r_state == OWN1) && w_win);
        // Nothing may be accepted while reset is held
        grant  = (w_any && rst_n) ? f_onehot(w_win) : 2'b00;
    end

    // Owner state, burst counter and tie-break pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OWN_NONE;
            r_bcnt  <= '0;
            r_ptr   <= 1'b0;
        end else if (!w_any) begin
            r_state <= OWN_NONE;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_win ? OWN1 : OWN0;
            if (w_yield) begin
                r_bcnt <= '0;
                r_ptr  <= ~r_ptr;
            end else if (w_same) begin
                // Saturate so an uncontended run cannot push the count out of range
                r_bcnt <= (r_bcnt == c_BLAST) ? r_bcnt : r_bcnt + c_BCW'(1);
            end else begin
                r_bcnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mini_ram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mini_ram_arb
//  Description : Arbitrates two requesters onto a single-port RAM. Registers
//                the accepted command, tags in-flight reads and returns read
//                data to the issuing port two cycles after acceptance.
//  Revision    : 1.0  initial release
// ============================================================================
module mini_ram_arb
    import mini_ram_arb_pkg::*;
#(
    parameter int AW        = c_AW,
    parameter int DW        = c_DW,
    parameter int MAX_BURST = c_MAX_BURST
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mini_ram_arb_if.slave  bus
);

    logic [1:0]    w_grant;
    logic          w_acc;
    logic          w_sel;
    logic          w_wr;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    logic          r_wr;
    logic          r_rd;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    tag_t          r_tag0;
    tag_t          r_tag1;

    mini_rr_arb2 #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid ({bus.p1_valid, bus.p0_valid}),
        .grant (w_grant)
    );

    assign bus.p0_ready = w_grant[0];
    assign bus.p1_ready = w_grant[1];

    // Select the winning port's request fields
    always_comb begin
        w_acc   = |w_grant;
        w_sel   = w_grant[1];
        w_wr    = w_sel ? bus.p1_wr    : bus.p0_wr;
        w_addr  = w_sel ? bus.p1_addr  : bus.p0_addr;
        w_wdata = w_sel ? bus.p1_wdata : bus.p0_wdata;
    end

    // Command register: one RAM command per accepted request, zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_wr    <= w_acc & w_wr;
            r_rd    <= w_acc & ~w_wr;
            r_addr  <= w_acc ? w_addr : '0;
            r_wdata <= (w_acc & w_wr) ? w_wdata : '0;
        end
    end

    // Two-stage tag pipe lining reads up with the RAM's one-cycle data return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag0 <= '0;
            r_tag1 <= '0;
        end else begin
            r_tag0 <= '{vld: w_acc & ~w_wr, id: w_sel};
            r_tag1 <= r_tag0;
        end
    end

    assign bus.ram_wr    = r_wr;
    assign bus.ram_rd    = r_rd;
    assign bus.ram_addr  = r_addr;
    assign bus.ram_wdata = r_wdata;

    // Response demux: data is gated so idle ports present zero
    assign bus.p0_rvalid = r_tag1.vld & ~r_tag1.id;
    assign bus.p1_rvalid = r_tag1.vld &  r_tag1.id;
    assign bus.p0_rdata  = bus.p0_rvalid ? bus.ram_rdata : '0;
    assign bus.p1_rdata  = bus.p1_rvalid ? bus.ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mini_ram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mini_ram_arb
//  Description : Directed self-checking bench for mini_ram_arb with a
//                behavioural single-port RAM (one-cycle read latency).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mini_ram_arb;

    typedef struct {
        logic       v0, w0;
        logic [7:0] a0, d0;
        logic       v1, w1;
        logic [7:0] a1, d1;
        logic       e_rdy0, e_rdy1, e_wr, e_rd;
        logic [7:0] e_addr, e_wdata;
        logic       e_rv0;
        logic [7:0] e_rd0;
        logic       e_rv1;
        logic [7:0] e_rd1;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] mem [256];
    vec_t       vecs [10];
    logic       pat [12];

    mini_ram_arb_if #(.AW(8), .DW(8)) bus ();

    mini_ram_arb #(
        .AW        (8),
        .DW        (8),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write on ram_wr, data returned the cycle after ram_rd
    always @(posedge clk) begin
        if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_rd) bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.p0_valid = 1'b0; bus.p0_wr = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_valid = 1'b0; bus.p1_wr = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rdy0"},  bus.p0_ready,  0);
        chk({nm, "_rdy1"},  bus.p1_ready,  0);
        chk({nm, "_rv0"},   bus.p0_rvalid, 0);
        chk({nm, "_rv1"},   bus.p1_rvalid, 0);
        chk({nm, "_rd0"},   bus.p0_rdata,  0);
        chk({nm, "_rd1"},   bus.p1_rdata,  0);
        chk({nm, "_wr"},    bus.ram_wr,    0);
        chk({nm, "_rd"},    bus.ram_rd,    0);
        chk({nm, "_addr"},  bus.ram_addr,  0);
        chk({nm, "_wdata"}, bus.ram_wdata, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h11;
        mem[8'h21] = 8'h22;
        mem[8'h30] = 8'hA0;
        mem[8'h31] = 8'hA1;
        for (int i = 0; i < 8; i++) mem[8'h40 + i] = 8'hC0 + 8'(i);
        bus.ram_rdata = 8'h00;

        //          v0 w0 a0     d0     v1 w1 a1     d1     rdy0 rdy1 wr rd addr  wdata  rv0 rd0    rv1 rd1
        vecs[0] = '{1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00};
        vecs[1] = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h10, 8'h5A, 0, 8'h00, 0, 8'h00};
        vecs[2] = '{1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h10, 8'h00, 0, 8'h00, 0, 8'h00};
        vecs[3] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h21, 8'h00, 0, 1, 0, 1, 8'h20, 8'h00, 1, 8'h5A, 0, 8'h00};
        vecs[4] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 8'hFF, 0, 1, 0, 1, 8'h21, 8'h00, 1, 8'h11, 0, 8'h00};
        vecs[5] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 0, 1, 1, 0, 8'hFF, 8'hFF, 0, 8'h00, 1, 8'h22};
        vecs[6] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 0, 1, 8'hFF, 8'h00, 0, 8'h00, 0, 8'h00};
        vecs[7] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 1, 8'hFF};
        vecs[8] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h00};
        vecs[9] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00};

        pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

        // Reset: outputs zero, requests ignored
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        bus.p0_valid = 1'b1;
        bus.p1_valid = 1'b1;
        @(negedge clk);
        chk_zero("reset");
        idle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Table: write/read-back, port-tagged returns, 0xFF boundary address
        for (int r = 0; r < 10; r++) begin
            bus.p0_valid = vecs[r].v0; bus.p0_wr = vecs[r].w0;
            bus.p0_addr  = vecs[r].a0; bus.p0_wdata = vecs[r].d0;
            bus.p1_valid = vecs[r].v1; bus.p1_wr = vecs[r].w1;
            bus.p1_addr  = vecs[r].a1; bus.p1_wdata = vecs[r].d1;
            @(negedge clk);
            chk($sformatf("vec%0d_rdy0", r),  bus.p0_ready,  vecs[r].e_rdy0);
            chk($sformatf("vec%0d_rdy1", r),  bus.p1_ready,  vecs[r].e_rdy1);
            chk($sformatf("vec%0d_wr", r),    bus.ram_wr,    vecs[r].e_wr);
            chk($sformatf("vec%0d_rd", r),    bus.ram_rd,    vecs[r].e_rd);
            chk($sformatf("vec%0d_addr", r),  bus.ram_addr,  vecs[r].e_addr);
            chk($sformatf("vec%0d_wdata", r), bus.ram_wdata, vecs[r].e_wdata);
            chk($sformatf("vec%0d_rv0", r),   bus.p0_rvalid, vecs[r].e_rv0);
            chk($sformatf("vec%0d_rdat0", r), bus.p0_rdata,  vecs[r].e_rd0);
            chk($sformatf("vec%0d_rv1", r),   bus.p1_rvalid, vecs[r].e_rv1);
            chk($sformatf("vec%0d_rdat1", r), bus.p1_rdata,  vecs[r].e_rd1);
            next_cycle();
        end
        idle();

        // Contention: both ports hold reads for 12 cycles, bursts of 4
        bus.p0_valid = 1'b1; bus.p0_addr = 8'h30;
        bus.p1_valid = 1'b1; bus.p1_addr = 8'h31;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_rdy0", i), bus.p0_ready, !pat[i]);
            chk($sformatf("rr%0d_rdy1", i), bus.p1_ready, pat[i]);
            if (i >= 2) begin
                chk($sformatf("rr%0d_rv0", i), bus.p0_rvalid, !pat[i-2]);
                chk($sformatf("rr%0d_rv1", i), bus.p1_rvalid, pat[i-2]);
                chk($sformatf("rr%0d_data", i),
                    pat[i-2] ? bus.p1_rdata : bus.p0_rdata, pat[i-2] ? 8'hA1 : 8'hA0);
            end
            next_cycle();
        end
        idle();
        repeat (2) next_cycle();

        // Single requester streams every cycle
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                bus.p1_valid = 1'b1;
                bus.p1_addr  = 8'h40 + 8'(i);
            end else begin
                idle();
            end
            @(negedge clk);
            if (i < 8) begin
                chk($sformatf("p1only%0d_rdy1", i), bus.p1_ready, 1);
                chk($sformatf("p1only%0d_rdy0", i), bus.p0_ready, 0);
            end
            chk($sformatf("p1only%0d_rv0", i), bus.p0_rvalid, 0);
            chk($sformatf("p1only%0d_rv1", i), bus.p1_rvalid, (i >= 2));
            if (i >= 2)
                chk($sformatf("p1only%0d_data", i), bus.p1_rdata, 8'hC0 + 8'(i - 2));
            next_cycle();
        end
        idle();
        next_cycle();

        // Reset while a p1 read is in flight
        bus.p1_valid = 1'b1; bus.p1_addr = 8'h21;
        @(negedge clk);
        chk("mid_acc_rdy1", bus.p1_ready, 1);
        next_cycle();
        idle();
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_zero("mid_rst0");
        bus.p0_valid = 1'b1;
        bus.p1_valid = 1'b1;
        @(negedge clk);
        chk_zero("mid_rst1");
        idle();
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_rv1", i), bus.p1_rvalid, 0);
            chk($sformatf("post_rst%0d_rv0", i), bus.p0_rvalid, 0);
            chk($sformatf("post_rst%0d_rd", i),  bus.ram_rd,    0);
            next_cycle();
        end

        // Arbiter restarted idle: contention goes to port 0 despite p1 owning before reset
        bus.p0_valid = 1'b1; bus.p0_addr = 8'h20;
        bus.p1_valid = 1'b1; bus.p1_addr = 8'h21;
        @(negedge clk);
        chk("restart_rdy0", bus.p0_ready, 1);
        chk("restart_rdy1", bus.p1_ready, 0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("restart_rd",   bus.ram_rd,   1);
        chk("restart_addr", bus.ram_addr, 8'h20);
        next_cycle();
        @(negedge clk);
        chk("restart_rv0",  bus.p0_rvalid, 1);
        chk("restart_data", bus.p0_rdata,  8'h11);
        chk("restart_rv1",  bus.p1_rvalid, 0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
